// File: rtl/sync_fifo_ctl_pkg.sv
// Shared elaboration helpers for the sync_fifo_ctl buffer: pointer-width derivation and
// parameter legality checks.
package sync_fifo_ctl_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Pointer width; count is one bit wider so it can represent DEPTH itself.
    function automatic int unsigned aw_of(input int unsigned depth);
        return clog2(depth);
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned depth,
                                     input int unsigned aempty_th,
                                     input int unsigned afull_th);
        return (width >= 1) && (depth >= 4) && ((depth & (depth - 1)) == 0) &&
               (aempty_th < afull_th) && (afull_th <= depth);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Register-array FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module sync_fifo_mem #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller: pointers, occupancy count, threshold and sticky error flags,
// and a first-word-fall-through or registered read port.
module sync_fifo_ctl
    import sync_fifo_ctl_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AFULL_TH  = DEPTH - 2,
    parameter int unsigned AEMPTY_TH = 2,
    parameter bit          FWFT      = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       din,
    output logic                   full,
    output logic                   almost_full,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       dout,
    output logic                   dout_valid,
    output logic                   empty,
    output logic                   almost_empty,
    output logic [aw_of(DEPTH):0]  count,
    input  logic                   err_clr,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned AW = aw_of(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW:0] DepthCnt  = CW'(DEPTH);
    localparam logic [AW:0] AfullCnt  = CW'(AFULL_TH);
    localparam logic [AW:0] AemptyCnt = CW'(AEMPTY_TH);

    if (!params_ok(WIDTH, DEPTH, AEMPTY_TH, AFULL_TH)) begin : g_bad_params
        $error("sync_fifo_ctl: illegal WIDTH/DEPTH/threshold configuration");
    end

    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             full_q, empty_q, afull_q, aempty_q;
    logic             overflow_q, underflow_q;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] mem_rdata;

    // Acceptance is judged against the registered flags, so at full a read frees no slot
    // for a same-cycle write.
    assign wr_acc = wr_en & ~full_q;
    assign rd_acc = rd_en & ~empty_q;

    always_comb begin
        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q     <= count_d;
            full_q      <= (count_d == DepthCnt);
            empty_q     <= (count_d == '0);
            afull_q     <= (count_d >= AfullCnt);
            aempty_q    <= (count_d <= AemptyCnt);
            // A new error wins over a same-cycle clear.
            overflow_q  <= (overflow_q & ~err_clr) | (wr_en & full_q);
            underflow_q <= (underflow_q & ~err_clr) | (rd_en & empty_q);
        end
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i     (clk),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (din),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (mem_rdata)
    );

    if (FWFT) begin : g_fwft
        assign dout       = mem_rdata;
        assign dout_valid = ~empty_q;
    end else begin : g_reg_read
        logic [WIDTH-1:0] dout_q;
        logic             dout_valid_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dout_q       <= '0;
                dout_valid_q <= 1'b0;
            end else begin
                dout_valid_q <= rd_acc;
                if (rd_acc) begin
                    dout_q <= mem_rdata;
                end
            end
        end

        assign dout       = dout_q;
        assign dout_valid = dout_valid_q;
    end

    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Directed bench for sync_fifo_ctl: a FWFT instance driven from a vector table plus
// queue-modelled sequences, and a registered-read instance for the FWFT=0 timing.
module tb_sync_fifo_ctl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
    logic [15:0] din = '0;
    logic        full, almost_full, empty, almost_empty, dout_valid, overflow, underflow;
    logic [15:0] dout;
    logic [4:0]  count;

    logic        r_wr = 1'b0, r_rd = 1'b0, r_clr = 1'b0;
    logic [15:0] r_din = '0;
    logic        r_full, r_af, r_empty, r_ae, r_dv, r_ov, r_un;
    logic [15:0] r_dout;
    logic [4:0]  r_count;

    int n_checks = 0;
    int n_fail = 0;

    logic [15:0] mq[$];
    logic        m_ov = 1'b0, m_un = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_ctl #(.WIDTH(16), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .din(din), .full(full),
        .almost_full(almost_full), .rd_en(rd_en), .dout(dout), .dout_valid(dout_valid),
        .empty(empty), .almost_empty(almost_empty), .count(count), .err_clr(err_clr),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_ctl #(.WIDTH(16), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1'b0)) dut_r (
        .clk(clk), .reset_n(reset_n), .wr_en(r_wr), .din(r_din), .full(r_full),
        .almost_full(r_af), .rd_en(r_rd), .dout(r_dout), .dout_valid(r_dv),
        .empty(r_empty), .almost_empty(r_ae), .count(r_count), .err_clr(r_clr),
        .overflow(r_ov), .underflow(r_un)
    );

    typedef struct {
        logic        wr, rd, clr;
        logic [15:0] din;
        logic [4:0]  cnt;
        logic        full, empty, af, ae, ov, un, dv;
        logic [15:0] dout;
    } vec_t;

    vec_t vecs[10];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock of stimulus on the FWFT instance, with the reference queue updated from the
    // pre-edge occupancy.
    task automatic cyc(input logic w, input logic r, input logic c, input logic [15:0] d);
        logic full_pre, empty_pre;
        full_pre  = (mq.size() == 16);
        empty_pre = (mq.size() == 0);
        wr_en = w; rd_en = r; err_clr = c; din = d;
        step();
        if (r && !empty_pre) void'(mq.pop_front());
        if (w && !full_pre) mq.push_back(d);
        m_ov = (m_ov && !c) || (w && full_pre);
        m_un = (m_un && !c) || (r && empty_pre);
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chkw({tag, " count"}, 16'(count), 16'(mq.size()));
        chk1({tag, " full"}, full, mq.size() == 16);
        chk1({tag, " empty"}, empty, mq.size() == 0);
        chk1({tag, " almost_full"}, almost_full, mq.size() >= 14);
        chk1({tag, " almost_empty"}, almost_empty, mq.size() <= 2);
        chk1({tag, " overflow"}, overflow, m_ov);
        chk1({tag, " underflow"}, underflow, m_un);
        chk1({tag, " dout_valid"}, dout_valid, mq.size() != 0);
        if (mq.size() != 0) chkw({tag, " dout"}, dout, mq[0]);
    endtask

    task automatic check_reset_state(input string tag);
        chkw({tag, " count"}, 16'(count), 16'd0);
        chk1({tag, " empty"}, empty, 1'b1);
        chk1({tag, " almost_empty"}, almost_empty, 1'b1);
        chk1({tag, " full"}, full, 1'b0);
        chk1({tag, " almost_full"}, almost_full, 1'b0);
        chk1({tag, " overflow"}, overflow, 1'b0);
        chk1({tag, " underflow"}, underflow, 1'b0);
        chk1({tag, " dout_valid"}, dout_valid, 1'b0);
    endtask

    initial begin
        //            wr    rd    clr   din        cnt   full  empty af    ae    ov    un    dv    dout
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0001, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 16'h0002, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h0004, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0002};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0004};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 16'h1234, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 16'h0000, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234};
        vecs[9] = '{1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};

        step();
        step();
        check_reset_state("reset");
        chk1("reg reset dout_valid", r_dv, 1'b0);
        chkw("reg reset dout", r_dout, 16'h0000);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            cyc(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
            chkw({t, " count"}, 16'(count), 16'(vecs[i].cnt));
            chk1({t, " full"}, full, vecs[i].full);
            chk1({t, " empty"}, empty, vecs[i].empty);
            chk1({t, " almost_full"}, almost_full, vecs[i].af);
            chk1({t, " almost_empty"}, almost_empty, vecs[i].ae);
            chk1({t, " overflow"}, overflow, vecs[i].ov);
            chk1({t, " underflow"}, underflow, vecs[i].un);
            chk1({t, " dout_valid"}, dout_valid, vecs[i].dv);
            if (vecs[i].dv) chkw({t, " dout"}, dout, vecs[i].dout);
        end

        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 16'h0100 + 16'(i));
            check_model($sformatf("fill%0d", i));
        end
        chk1("fill full", full, 1'b1);
        chkw("fill count", 16'(count), 16'd16);

        cyc(1'b1, 1'b0, 1'b0, 16'hDEAD);
        check_model("ovf write");
        chk1("ovf set", overflow, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 16'hDEAD);
        check_model("ovf clr+err");
        cyc(1'b0, 1'b0, 1'b1, 16'h0000);
        check_model("ovf clr");
        chk1("ovf cleared", overflow, 1'b0);

        cyc(1'b1, 1'b1, 1'b0, 16'hBEEF);
        check_model("full wr+rd");
        chkw("full wr+rd count", 16'(count), 16'd15);
        chkw("full wr+rd dout", dout, 16'h0101);

        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 16'h0000);
            check_model($sformatf("drain%0d", i));
        end

        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 16'h2000 + 16'(i));
            check_model($sformatf("stream%0d", i));
        end
        chkw("stream count", 16'(count), 16'd8);
        chkw("stream head", dout, 16'h2000 + 16'd92);

        cyc(1'b1, 1'b0, 1'b0, 16'h3000);
        check_model("pre-reset");
        chkw("pre-reset count", 16'(count), 16'd9);

        // Asynchronous reset mid-cycle, checked before any further clock edge.
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_state("async reset");
        step();
        reset_n = 1'b1;
        mq.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 16'h4242);
        check_model("post-reset write");

        r_wr = 1'b1; r_din = 16'hA5A5;
        step();
        r_wr = 1'b0;
        chk1("reg after write dv", r_dv, 1'b0);
        r_rd = 1'b1;
        step();
        r_rd = 1'b0;
        chk1("reg read dv", r_dv, 1'b1);
        chkw("reg read dout", r_dout, 16'hA5A5);
        step();
        chk1("reg idle dv", r_dv, 1'b0);
        chkw("reg idle dout hold", r_dout, 16'hA5A5);

        r_wr = 1'b1; r_din = 16'h1111;
        step();
        r_din = 16'h2222;
        step();
        r_wr = 1'b0; r_rd = 1'b1;
        step();
        chk1("reg b2b dv0", r_dv, 1'b1);
        chkw("reg b2b dout0", r_dout, 16'h1111);
        step();
        chk1("reg b2b dv1", r_dv, 1'b1);
        chkw("reg b2b dout1", r_dout, 16'h2222);
        step();
        r_rd = 1'b0;
        chk1("reg empty read dv", r_dv, 1'b0);
        chk1("reg empty read underflow", r_un, 1'b1);
        chkw("reg empty read dout hold", r_dout, 16'h2222);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctl.md
# sync_fifo_ctl

Parametrised single-clock FIFO with occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a selectable read mode (first-word-fall-through or registered read). It is the next-generation buffer between a data source and a data sink in the same clock domain. It generalises the fixed 16-bit source→FIFO→sink path to any width and depth, and adds error reporting and flow-control margins.

## Interface
Parameters:
- WIDTH, 16, data width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- AFULL_TH, DEPTH-2, almost_full asserts when count ≥ AFULL_TH
- AEMPTY_TH, 2, almost_empty asserts when count ≤ AEMPTY_TH
- FWFT, 1, 1 = first-word-fall-through, 0 = registered read

Ports (AW = log2(DEPTH)):
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write request
- din  in  WIDTH  write data
- full  out  1  FIFO holds DEPTH entries
- almost_full  out  1  count ≥ AFULL_TH
- rd_en  in  1  read request
- dout  out  WIDTH  read data
- dout_valid  out  1  dout holds a valid word
- empty  out  1  FIFO holds 0 entries
- almost_empty  out  1  count ≤ AEMPTY_TH
- count  out  AW+1  current occupancy, 0..DEPTH
- err_clr  in  1  clears sticky error flags
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage is a DEPTH×WIDTH register array with an AW-bit write pointer and an AW-bit read pointer. Pointers wrap modulo DEPTH. The count register is AW+1 bits wide and is the sole source of full/empty: full = (count==DEPTH), empty = (count==0).
- Write accepted = wr_en & ~full. An accepted write stores din at wr_ptr and increments wr_ptr.
- Read accepted = rd_en & ~empty. An accepted read increments rd_ptr.
- Count changes by +1 on write-only, −1 on read-only, and is unchanged when both or neither are accepted.
- Full with wr_en & rd_en: the read is accepted and the write is dropped, with overflow set. full is evaluated before the read.
- Empty with wr_en & rd_en: the write is accepted and the read is rejected, with underflow set.
- Rejected writes and reads change no pointer, count or storage.
- overflow/underflow set on a rejected access and hold until err_clr. If err_clr and a new error occur in the same cycle, the flag stays set.
- FWFT=1: dout = mem[rd_ptr] combinationally; dout_valid = ~empty; rd_en pops the word currently shown.
- FWFT=0: on an accepted read, dout registers mem[rd_ptr] and dout_valid pulses high for exactly the next cycle. dout holds its last value otherwise.
- All flags and count are registered outputs (FWFT=1 dout excepted).
- Reset (async assert, sync-released by the system): pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0 (when AFULL_TH>0), overflow=0, underflow=0, dout_valid=0, registered dout=0. Storage contents are not reset. Reset mid-operation discards all contents immediately.

## Timing
- Write accepted at edge N: count, empty, almost_* and full reflect it after edge N. FWFT=1 dout/dout_valid show the word after edge N (1-cycle write-to-read latency).
- FWFT=0 read accepted at edge N: dout/dout_valid valid after edge N, deasserting after N+1 unless another read is accepted.
- Sustained simultaneous read and write: throughput 1 word/cycle in both directions, count constant.
- Flag thresholds compare the next-state count so that flags and count change on the same edge.

## Structure
- A shared package holds: the clog2 function, the AW derivation, and an elaboration-time check macro/constant for DEPTH power-of-two and 0 ≤ AEMPTY_TH < AFULL_TH ≤ DEPTH.
- One natural sub-module, sync_fifo_mem: register-array storage with write port and async read port. The top level holds pointers, count, flags and the FWFT/registered output mux.

## Test plan
- Reset, then write 0x0001,0x0002,0x0004 (WIDTH=16, DEPTH=16, FWFT=1) → dout=0x0001 one cycle after first write; three rd_en pops yield 0x0001,0x0002,0x0004, then empty=1, count=0.
- Fill with 16 writes → full=1 and count=16 after 16th edge; almost_full=1 from count=14; 17th wr_en sets overflow with count unchanged; err_clr clears it.
- rd_en while empty → underflow=1, dout_valid=0, rd_ptr unchanged; a simultaneous wr_en still stores data and count becomes 1.
- At full, wr_en & rd_en together → read accepted, write dropped, count=15, overflow=1. At count=8, both together for 100 cycles → count stays 8 and order is preserved across pointer wrap.
- FWFT=0 build: write 0xA5A5, then rd_en → dout=0xA5A5 and dout_valid=1 for exactly one cycle after the read edge.
- Assert reset_n low mid-stream at count=9, asynchronously between edges → count=0, empty=1 and flags cleared without waiting for a clock edge.
